// File: rtl/board_judge.sv
// Tic-tac-toe board with move checking and a sequential win/draw line scanner.
// Optional macro BOARD_SCAN_EARLY_EXIT_EN ends a scan on the first winning line.
`timescale 1ns/1ps
module board_judge (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       w_e,
  input  logic [3:0] pos,
  input  logic [1:0] player,
  output logic [1:0] cell_state,
  input  logic [3:0] rd_pos,
  output logic [1:0] rd_state,
  output logic       busy,
  output logic       win,
  output logic [1:0] winner,
  output logic       full,
  output logic       err
);

`ifdef BOARD_SCAN_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic {IDLE, SCAN} state_e;

  state_e     state_q, state_d;
  logic [2:0] line_q, line_d;
  logic [1:0] cells_q [9];
  logic       win_q, full_q, err_q;
  logic [1:0] winner_q;

  logic [3:0] idx_a, idx_b, idx_c;
  logic       line_hit, scan_done, accept, board_full, legal_player;

  // Line order: rows, columns, then the two diagonals.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2;
    case (line_q)
      3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
      3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
      3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
      3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
      3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
      3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
      3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
      default: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
    endcase
  end

  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cells_q[i] == 2'b00) board_full = 1'b0;
    end
  end

  assign line_hit     = (cells_q[idx_a] != 2'b00) &&
                        (cells_q[idx_a] == cells_q[idx_b]) &&
                        (cells_q[idx_a] == cells_q[idx_c]);
  assign scan_done    = (state_q == SCAN) && ((line_q == 3'd7) || (EARLY_EXIT && line_hit));
  assign legal_player = (player == 2'b01) || (player == 2'b10);
  assign accept       = w_e && !clr && (state_q == IDLE) && !win_q && (pos <= 4'd8) &&
                        (cells_q[pos] == 2'b00) && legal_player;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      line_q  <= 3'd0;
    end else begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      state_q <= state_d;
      line_q  <= line_d;
    end
  end

  // Next-state logic; clr aborts a scan from any state.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    if (clr) begin
      state_d = IDLE;
      line_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_d = SCAN;
          line_d  = 3'd0;
        end
        SCAN: if (scan_done) state_d = IDLE;
              else           line_d  = line_q + 3'd1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == SCAN);
  end

  // Board and verdict registers. A line only latches while win is still clear,
  // so the first winning line is the one that sticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the cell array is small and its reset value is architectural, so it is reset.
      for (int i = 0; i < 9; i++) cells_q[i] <= 2'b00;
      win_q    <= 1'b0;
      winner_q <= 2'b00;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < 9; i++) cells_q[i] <= 2'b00;
      win_q    <= 1'b0;
      winner_q <= 2'b00;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= w_e && !accept;
      for (int i = 0; i < 9; i++) begin
        if (accept && (pos == 4'(i))) cells_q[i] <= player;
      end
      if ((state_q == SCAN) && line_hit && !win_q) begin
        win_q    <= 1'b1;
        winner_q <= cells_q[idx_a];
      end
      if (scan_done) full_q <= board_full;
    end
  end

  assign cell_state = (pos    <= 4'd8) ? cells_q[pos]    : 2'b00;
  assign rd_state   = (rd_pos <= 4'd8) ? cells_q[rd_pos] : 2'b00;
  assign win        = win_q;
  assign winner     = winner_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: doc/board_judge.md
BOARD_JUDGE -- requirements
Module: board_judge

Interface
REQ-001 The block SHALL provide clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL provide rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide clr, input, 1 bit: synchronous new-game clear, active-high.
REQ-004 The block SHALL provide w_e, input, 1 bit: write request for the current move, sampled every rising edge.
REQ-005 The block SHALL provide pos, input, 4 bits: target cell index, 0-8 row-major; 9-15 are illegal.
REQ-006 The block SHALL provide player, input, 2 bits: 01 = player 1, 10 = player 2; 00 and 11 are illegal.
REQ-007 The block SHALL provide cell_state, output, 2 bits: combinational contents of cell pos; 00 when pos > 8.
REQ-008 The block SHALL provide rd_pos, input, 4 bits, and rd_state, output, 2 bits: combinational display read port; rd_state is 00 when rd_pos > 8.
REQ-009 The block SHALL provide busy, output, 1 bit: line scan in progress.
REQ-010 The block SHALL provide win, output, 1 bit, and winner, output, 2 bits: sticky game-won flag and winning code.
REQ-011 The block SHALL provide full, output, 1 bit: all 9 cells occupied, as of the last completed scan.
REQ-012 The block SHALL provide err, output, 1 bit: one-cycle pulse on a rejected write.

Function
REQ-013 Accept a write at edge k only when all of these hold: w_e=1, clr=0, busy=0, win=0, pos<=8, cell pos==00, and player is 01 or 10.
- On acceptance, store player into cell pos at edge k.
- busy rises after edge k.
REQ-014 Reject every other w_e=1 edge with no board change, and pulse err high for the following cycle.
- Exception: w_e together with clr is not an error.
REQ-015 The scan FSM SHALL have two states. IDLE moves to SCAN on an accepted write. SCAN evaluates one line per edge, at edges k+1 through k+8, in this order:
- 0-1-2, 3-4-5, 6-7-8 (rows)
- 0-3-6, 1-4-7, 2-5-8 (columns)
- 0-4-8, 2-4-6 (diagonals)
REQ-016 A line wins when its three cells are equal and nonzero. On the first winning line, latch win=1 and winner=that cell code; later lines never overwrite it.
REQ-017 Update full at edge k+8 from all 9 cells. win and full may both be 1; the consumer gives win priority.
REQ-018 busy SHALL fall at edge k+8, so win and full are valid in the same cycle busy first reads 0.
REQ-019 win, winner and board contents SHALL stay stable until clr or rst. After win=1, all writes are rejected with err.
REQ-020 clr at any edge SHALL do all of the following:
- zero all 9 cells and win, winner, full and err
- abort any scan
- return the FSM to IDLE
REQ-021 cell_state and rd_state SHALL reflect a write starting the cycle after the accepting edge.

Reset
REQ-022 While rst=0, immediately force all of the following, independent of clk:
- all 9 cells=00
- FSM=IDLE, busy=0
- win=0, winner=00, full=0, err=0
REQ-023 rst asserted mid-scan SHALL abandon the scan. After release, the first edge behaves as from IDLE on an empty board.

Configuration
REQ-024 With macro BOARD_SCAN_EARLY_EXIT_EN defined, SCAN terminates on the first winning line i (0-7).
- win, winner and full update, and busy falls, at edge k+1+i.
- full is evaluated at that same edge.
REQ-025 Without BOARD_SCAN_EARLY_EXIT_EN, every scan lasts exactly 8 edges, per REQ-015 to REQ-018.

Verification
REQ-026 Row win: the bench SHALL cover this scenario.
- Stimulus: P1 writes 0, P2 writes 3, P1 writes 1, P2 writes 4, P1 writes 2, each after busy=0.
- Response: after the last scan, win=1, winner=01, full=0.
- Also check busy lasts 8 cycles (macro off), or drops at edge k+1 (macro on, line 0).
REQ-027 Draw: the bench SHALL cover this scenario.
- Stimulus: fill the cells in the order 0,1,2,4,3,5,7,6,8 with alternating P1/P2.
- Response: full=1 and win=0 after the final scan.
REQ-028 Illegal writes: the bench SHALL cover this scenario.
- Stimulus: write pos=9; write an occupied cell; write player=11; write while busy=1.
- Response: each gives a one-cycle err pulse and no change to cell_state or rd_state.
REQ-029 Anti-diagonal win: the bench SHALL cover this scenario.
- Stimulus: P2 wins on 2-4-6.
- Response: winner=10 with busy falling at edge k+8 (macro off) or k+8 (macro on, line 7).
- Also check a subsequent write gives err with the board unchanged.
REQ-030 Abort: the bench SHALL cover this scenario.
- Stimulus: assert clr at edge k+3 of a scan, then separately assert rst low mid-scan.
- Response: board reads all 00, busy=0, win=0, full=0; the next legal write is accepted normally.
